// File: rtl/mul_pipe_unit_if.sv
// mul_pipe_unit_if: issue, flush and CDB result bundle of the pipelined multiplier
// master = reservation station / CDB side, slave = multiply unit
//   in_valid/in_ready/in_op/in_a/in_b/in_tag  issue handshake and operands
//   flush                                     kill every in-flight op
//   out_valid/out_ack/out_result/out_tag      result handshake towards the CDB
//   inflight                                  ops held in the pipe incl. output stage
interface mul_pipe_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int LG_W = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ack;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic [LG_W+1:0]  inflight;
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, out_ack,
        input  in_ready, out_valid, out_result, out_tag, inflight
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ack,
        output in_ready, out_valid, out_result, out_tag, inflight
    );
endinterface

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: fully pipelined tagged integer multiplier (MUL/MULH/MULHU/MULHSU)
// Ports:
//   clk   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   mul_pipe_unit_if.slave: issue handshake, flush, CDB result handshake, inflight
// Pipe: S0 partial products, LG_W adder-tree levels, output register (L = LG_W+2).
module mul_pipe_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           nRST,
    mul_pipe_unit_if.slave bus
);
    localparam int LG_W  = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam int NODES = PW - 1;
    localparam int CW    = LG_W + 2;

    logic                         adv, accept, a_neg, b_neg;
    logic [WIDTH-1:0]             a_mag, b_mag;
    // All tree levels packed back to back: level k starts at PW - (PW >> k)
    logic [NODES-1:0][PW-1:0]     tree_q, tree_d;
    logic [LG_W:0]                vld_q, vld_d, neg_q, neg_d;
    logic [LG_W:0][1:0]           op_q, op_d;
    logic [LG_W:0][TAG_W-1:0]     tag_q, tag_d;
    logic [PW-1:0]                sum, prod;
    logic                         out_valid_q;
    logic [WIDTH-1:0]             out_result_q, out_result_d;
    logic [TAG_W-1:0]             out_tag_q;
    logic [CW-1:0]                count;

    // Only a presented, un-acked result blocks the pipe; bubbles always advance
    assign adv    = ~(out_valid_q & ~bus.out_ack);
    assign accept = bus.in_valid & adv;

    // a is signed for MULH/MULHSU, b only for MULH; -MIN wraps to 2^(W-1), read as unsigned
    assign a_neg = (bus.in_op == 2'b01 || bus.in_op == 2'b11) & bus.in_a[WIDTH-1];
    assign b_neg = (bus.in_op == 2'b01) & bus.in_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.in_a : bus.in_a;
    assign b_mag = b_neg ? -bus.in_b : bus.in_b;

    assign vld_d = {vld_q[LG_W-1:0], accept};
    assign neg_d = {neg_q[LG_W-1:0], a_neg ^ b_neg};
    assign op_d  = {op_q[LG_W-1:0], bus.in_op};
    assign tag_d = {tag_q[LG_W-1:0], bus.in_tag};

    always_comb begin
        tree_d = '0;
        for (int i = 0; i < WIDTH; i++)
            tree_d[i] = b_mag[i] ? {{WIDTH{1'b0}}, a_mag} << i : '0;
        for (int k = 1; k <= LG_W; k++)
            for (int i = 0; i < (WIDTH >> k); i++)
                tree_d[PW - (PW >> k) + i] = tree_q[PW - (PW >> (k - 1)) + i]
                                           + tree_q[PW - (PW >> (k - 1)) + i + (WIDTH >> k)];
    end

    assign sum          = tree_q[NODES-1];
    assign prod         = neg_q[LG_W] ? -sum : sum;
    assign out_result_d = op_q[LG_W] == 2'b00 ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];

    always_comb begin
        count = CW'(out_valid_q);
        for (int k = 0; k <= LG_W; k++)
            count = count + CW'(vld_q[k]);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            if (bus.flush) begin
                vld_q       <= '0;
                out_valid_q <= 1'b0;
            end else if (adv) begin
                vld_q       <= vld_d;
                out_valid_q <= vld_q[LG_W];
            end
            if (adv) begin
                out_result_q <= out_result_d;
                out_tag_q    <= tag_q[LG_W];
            end
        end
    end

    // Datapath needs no reset: nothing downstream looks at it without a valid bit
    always_ff @(posedge clk) begin
        if (adv) begin
            tree_q <= tree_d;
            neg_q  <= neg_d;
            op_q   <= op_d;
            tag_q  <= tag_d;
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.inflight   = count;
endmodule
